// File: rtl/fc_arb_pkg.sv
// Shared constants, FSM encoding and counter sizing for the FIFO round-robin arbiter.
package fc_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HALT   = 2'd2
    } state_t;

    // Bits needed to hold a count from 0 up to max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: grants the first requester after `last`, wrapping,
// so `last` itself has the lowest priority.
module rr_pick
    import fc_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gnt,
    output logic              any
);

    logic [CH_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
        gnt = last;
        any = 1'b0;
        idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest requester wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = last + CH_W'(k);
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains four input VC FIFOs into one output FIFO with round-robin bursts.
// Build option ARB_STRICT_PRIO_EN: channel 0 becomes strict priority, channels 1-3 rotate.
module fifo_rr_arbiter
    import fc_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int BURST      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic [NUM_CH-1:0]            empty,
    input  logic [NUM_CH-1:0]            almost_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            pausa,
    input  logic                         error_full,
    input  logic                         out_full,
    input  logic                         out_almost_full,
    output logic [NUM_CH-1:0]            pop,
    output logic                         out_push,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              grant,
    output logic                         halted
);

`ifdef ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    localparam int CNT_W = cnt_width(BURST);

    state_t              state;
    logic [CH_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    burst_cnt;
    logic [NUM_CH-1:0]   pop_q;
    logic [NUM_CH-1:0]   almost_empty_q;

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   pick_req;
    logic [CH_W-1:0]     pick_gnt;
    logic                pick_any;
    logic                stall;
    logic                keep;
    logic                issue;
    logic                fresh;
    logic [CH_W-1:0]     sel;

    rr_pick u_pick (
        .req  (pick_req),
        .last (rr_ptr),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    always_comb begin
        // A FIFO popped last cycle while holding its final entry still shows non-empty now.
        req      = ~empty & ~pausa & ~(pop_q & almost_empty_q);
        pick_req = STRICT ? (req & ~NUM_CH'(1)) : req;
        stall    = !enb || out_full || out_almost_full;
        // burst_cnt == 0 in ACTIVE marks a pending re-arbitration after a stall.
        keep     = (state == ACTIVE) && (burst_cnt != '0) &&
                   (burst_cnt < CNT_W'(BURST)) && req[grant];
        issue    = 1'b0;
        fresh    = 1'b0;
        sel      = grant;
        if (!rst && !error_full && state != HALT && !stall) begin
            if (STRICT && req[0]) begin
                issue = 1'b1;
                fresh = 1'b1;
                sel   = '0;
            end else if (keep) begin
                issue = 1'b1;
            end else if (pick_any) begin
                issue = 1'b1;
                fresh = 1'b1;
                sel   = pick_gnt;
            end
        end
        pop = issue ? (NUM_CH'(1) << sel) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= '0;
            rr_ptr         <= CH_W'(NUM_CH - 1);
            burst_cnt      <= '0;
            pop_q          <= '0;
            almost_empty_q <= '0;
            out_push       <= 1'b0;
            out_data       <= '0;
            halted         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            pop_q          <= pop;
            almost_empty_q <= almost_empty;
            out_push       <= issue;
            // Read data of the popped FIFO is captured at the edge that ends the pop cycle.
            if (issue) begin
                out_data <= data_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (error_full || state == HALT) begin
                state  <= HALT;
                halted <= 1'b1;
            end else if (issue) begin
                state     <= ACTIVE;
                grant     <= sel;
                burst_cnt <= fresh ? CNT_W'(1) : burst_cnt + CNT_W'(1);
                if (!(STRICT && sel == '0)) begin
                    rr_ptr <= sel;
                end
            end else if (stall) begin
                burst_cnt <= '0;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
